// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host byte receiver: synchronises clock/data, frames start/8 data/odd parity/stop.
// Optional make/break filtering of 0xF0 prefixes is enabled with `define PS2_BREAK_FILTER_EN.
module ps2_scancode_rx #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic [1:0] fsm_state
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Handshake: valid, parity_err and frame_err are single-cycle, mutually exclusive
    // pulses with no back-pressure; scancode is stable whenever valid is high and after.

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    state_t          state, state_n;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [7:0]      shift, shift_n;
    logic            parity_ok, parity_ok_n;
    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic [7:0]      scancode_n;
    logic            valid_n, parity_err_n, frame_err_n;

    // Synchronisers idle high so reset release never looks like a falling edge.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clock};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign data_s    = data_sync[SYNC_STAGES-1];
    assign fall      = clk_prev & ~clk_s;
    assign fsm_state = state;

`ifdef PS2_BREAK_FILTER_EN
    logic break_pending, break_pending_n;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            break_pending <= 1'b0;
        end else begin
            break_pending <= break_pending_n;
        end
    end
`endif

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_ok  <= 1'b0;
            to_cnt     <= '0;
            scancode   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            parity_ok  <= parity_ok_n;
            to_cnt     <= to_cnt_n;
            scancode   <= scancode_n;
            valid      <= valid_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        parity_ok_n  = parity_ok;
        to_cnt_n     = to_cnt;
        scancode_n   = scancode;
        valid_n      = 1'b0;
        parity_err_n = 1'b0;
        frame_err_n  = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        break_pending_n = break_pending;
`endif

        // Counter saturates at the limit, so it can never wrap past it.
        if (state == IDLE || fall) begin
            to_cnt_n = '0;
        end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
            to_cnt_n = to_cnt + 1'b1;
        end

        if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                        shift_n   = '0;
                    end
                end
                DATA: begin
                    shift_n   = {data_s, shift[7:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    parity_ok_n = ^{shift, data_s};
                    state_n     = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!data_s) begin
                        frame_err_n = 1'b1;
                    end else if (!parity_ok) begin
                        parity_err_n = 1'b1;
                    end else begin
`ifdef PS2_BREAK_FILTER_EN
                        if (break_pending) begin
                            break_pending_n = 1'b0;
                        end else if (shift == 8'hF0) begin
                            break_pending_n = 1'b1;
                        end else begin
                            scancode_n = shift;
                            valid_n    = 1'b1;
                        end
`else
                        scancode_n = shift;
                        valid_n    = 1'b1;
`endif
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
            state_n     = IDLE;
            bit_cnt_n   = '0;
            shift_n     = '0;
            to_cnt_n    = '0;
            frame_err_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: good, bad-parity, bad-stop, timeout, break and reset frames.
// Build with +define+PS2_BREAK_FILTER_EN to check the break-filter variant.
module tb_ps2_scancode_rx;

    localparam int TIMEOUT = 300;
    localparam int HALF    = 20;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       ps2_clock;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic [1:0] fsm_state;

    int tests = 0;
    int fails = 0;
    int n_valid = 0, n_perr = 0, n_ferr = 0, n_overlap = 0;
    int v0, p0, f0;
    int stop_lat;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    ps2_scancode_rx #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .ps2_clock(ps2_clock),
        .ps2_data(ps2_data),
        .scancode(scancode),
        .valid(valid),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .fsm_state(fsm_state)
    );

    // 100 MHz clock
    always #5 clk_in = ~clk_in;

    // Pulse monitor: pulse counts, accepted bytes, exclusivity violations.
    always @(negedge clk_in) begin
        if (valid) begin
            n_valid++;
            got_q.push_back(scancode);
        end
        if (parity_err) n_perr++;
        if (frame_err) n_ferr++;
        if (int'(valid) + int'(parity_err) + int'(frame_err) > 1) n_overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        v0 = n_valid;
        p0 = n_perr;
        f0 = n_ferr;
    endtask

    // bits[0] goes first; stop_lat records cycles from the last falling edge to a pulse.
    task automatic send_bits(input logic [10:0] bits, input int n);
        stop_lat = 0;
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk_in);
            ps2_clock = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk_in);
                if (stop_lat == 0 && (valid || parity_err || frame_err)) stop_lat = k;
            end
            ps2_clock = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk_in);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bits({stp, par, d, 1'b0}, 11);
    endtask

    task automatic check_got(input string tag);
        logic [7:0] e;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, got_q.pop_front(), e);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        ps2_clock = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk_in);
        check("rst_scancode", scancode, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_state", fsm_state, 2'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk_in);
        check("post_rst_valid_cnt", n_valid, 0);

        // Good 0x16 (3 ones -> parity 0)
        snap();
        send_frame(8'h16, 1'b0, 1'b1);
        check("g16_valid", n_valid - v0, 1);
        check("g16_perr", n_perr - p0, 0);
        check("g16_ferr", n_ferr - f0, 0);
        check("g16_scancode", scancode, 8'h16);
        check("g16_latency", stop_lat, 3);
        check("g16_state", fsm_state, 2'd0);
        exp_q.push_back(8'h16);
        check_got("g16_byte");

        // 0x5A with wrong parity 0
        snap();
        send_frame(8'h5A, 1'b0, 1'b1);
        check("p5a_perr", n_perr - p0, 1);
        check("p5a_valid", n_valid - v0, 0);
        check("p5a_ferr", n_ferr - f0, 0);
        check("p5a_scancode", scancode, 8'h16);
        check("p5a_latency", stop_lat, 3);

        // 0x45, good parity 0, bad stop; then good 0x16
        snap();
        send_frame(8'h45, 1'b0, 1'b0);
        check("f45_ferr", n_ferr - f0, 1);
        check("f45_valid", n_valid - v0, 0);
        check("f45_perr", n_perr - p0, 0);
        check("f45_scancode", scancode, 8'h16);
        snap();
        send_frame(8'h16, 1'b0, 1'b1);
        check("f45_next_valid", n_valid - v0, 1);
        check("f45_next_scancode", scancode, 8'h16);
        got_q.delete();

        // Timeout: start + 3 data bits of 0x5A (0,1,0), then silence
        snap();
        send_bits(11'b000_0000_0100, 4);
        check("to_state_data", fsm_state, 2'd1);
        repeat (TIMEOUT - 150) @(negedge clk_in);
        check("to_early_ferr", n_ferr - f0, 0);
        check("to_early_state", fsm_state, 2'd1);
        repeat (200) @(negedge clk_in);
        check("to_ferr", n_ferr - f0, 1);
        check("to_valid", n_valid - v0, 0);
        check("to_state_idle", fsm_state, 2'd0);
        snap();
        send_frame(8'h5A, 1'b1, 1'b1);
        check("to_next_valid", n_valid - v0, 1);
        check("to_next_scancode", scancode, 8'h5A);
        got_q.delete();

        // Break sequence 0x16, 0xF0 (parity 1), 0x16
        snap();
        send_frame(8'h16, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h16, 1'b0, 1'b1);
`ifdef PS2_BREAK_FILTER_EN
        check("brk_valid", n_valid - v0, 1);
        exp_q.push_back(8'h16);
`else
        check("brk_valid", n_valid - v0, 3);
        exp_q.push_back(8'h16);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h16);
`endif
        check("brk_scancode", scancode, 8'h16);
        check("brk_errs", (n_perr - p0) + (n_ferr - f0), 0);
        check_got("brk_byte");

        // Reset after 5th data bit of 0x45 (1,0,1,0,0), then good 0x1E (parity 1)
        snap();
        send_bits(11'b000_0000_1010, 6);
        check("rm_state_data", fsm_state, 2'd1);
        reset = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rm_state_rst", fsm_state, 2'd0);
        check("rm_scancode_rst", scancode, 8'h00);
        reset = 1'b0;
        repeat (TIMEOUT + 20) @(negedge clk_in);
        check("rm_no_pulse", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
        send_frame(8'h1E, 1'b1, 1'b1);
        check("rm_next_valid", n_valid - v0, 1);
        check("rm_next_scancode", scancode, 8'h1E);
        exp_q.push_back(8'h1E);
        check_got("rm_byte");

        check("pulse_exclusive", n_overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
